// File: rtl/execute_cycle_pkg.sv
// rtl/execute_cycle_pkg.sv - shared encodings for the execute stage
//
// Purpose : ALU operation codes, forwarding-select codes and the default
//           datapath width used by execute_cycle and alu.
package execute_cycle_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/execute_cycle_alu.sv
// rtl/execute_cycle_alu.sv - execute-stage ALU
//
// Purpose : combinational ALU; add/sub wrap modulo 2^XLEN, slt is signed.
// Ports   : i_a, i_b   - operands (XLEN)
//           i_ctrl     - ALU operation (3 bits, see alu_ctrl_e)
//           o_result   - result (XLEN); codes 110/111 give 0
//           o_zero     - high when o_result == 0
module alu
    import execute_cycle_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [2:0]      i_ctrl,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero
);

    logic w_slt;

    assign w_slt = ($signed(i_a) < $signed(i_b));

    always_comb begin
        o_result = '0;
        case (i_ctrl)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            ALU_SLT: o_result = {{(XLEN-1){1'b0}}, w_slt};
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/execute_cycle.sv
// rtl/execute_cycle.sv - RISC-V style execute stage with EX/MEM register
//
// Purpose : operand forwarding, ALU, branch-target/branch-taken generation
//           and the execute-to-memory pipeline register.
// Ports   : clk, rst (async, active-low)
//           RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, control bits   - from decode
//           ForwardAE, ForwardBE  - forwarding selects from hazard unit
//           ResultW               - writeback result (forward path 01)
//           PCSrcE, PCTargetE     - combinational branch redirect
//           *M outputs            - registered memory-stage signals
module execute_cycle #(
    parameter int XLEN = execute_cycle_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RdE,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            ALUSrcE,
    input  logic            BranchE,
    input  logic            ResultSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            ResultSrcM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);
    import execute_cycle_pkg::*;

    logic [XLEN-1:0] w_src_a;
    logic [XLEN-1:0] w_write_data;
    logic [XLEN-1:0] w_src_b;
    logic [XLEN-1:0] w_alu_result;
    logic            w_zero;

    logic            r_reg_write;
    logic            r_mem_write;
    logic            r_result_src;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_alu_result;
    logic [XLEN-1:0] r_write_data;
    logic [XLEN-1:0] r_pc_plus4;

    // Path 10 takes the registered ALU result so a dependent op issued the
    // very next cycle sees its producer; 11 falls back to the register file.
    always_comb begin
        w_src_a = RD1E;
        case (ForwardAE)
            FWD_WB:  w_src_a = ResultW;
            FWD_MEM: w_src_a = r_alu_result;
            default: w_src_a = RD1E;
        endcase
    end

    always_comb begin
        w_write_data = RD2E;
        case (ForwardBE)
            FWD_WB:  w_write_data = ResultW;
            FWD_MEM: w_write_data = r_alu_result;
            default: w_write_data = RD2E;
        endcase
    end

    assign w_src_b = ALUSrcE ? ImmExtE : w_write_data;

    alu #(.XLEN(XLEN)) u_alu (
        .i_a      (w_src_a),
        .i_b      (w_src_b),
        .i_ctrl   (ALUControlE),
        .o_result (w_alu_result),
        .o_zero   (w_zero)
    );

    assign PCTargetE = PCE + ImmExtE;
    assign PCSrcE    = w_zero & BranchE;

    // Store data is the forwarded B value, not the raw RD2E.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_result_src <= 1'b0;
            r_rd         <= '0;
            r_alu_result <= '0;
            r_write_data <= '0;
            r_pc_plus4   <= '0;
        end else begin
            r_reg_write  <= RegWriteE;
            r_mem_write  <= MemWriteE;
            r_result_src <= ResultSrcE;
            r_rd         <= RdE;
            r_alu_result <= w_alu_result;
            r_write_data <= w_write_data;
            r_pc_plus4   <= PCPlus4E;
        end
    end

    assign RegWriteM  = r_reg_write;
    assign MemWriteM  = r_mem_write;
    assign ResultSrcM = r_result_src;
    assign RdM        = r_rd;
    assign ALUResultM = r_alu_result;
    assign WriteDataM = r_write_data;
    assign PCPlus4M   = r_pc_plus4;

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width in bits.
REQ-002 SHALL have clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have rst, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have RD1E, RD2E, input, XLEN, register-file read data from the decode stage.
REQ-005 SHALL have ImmExtE, PCE, PCPlus4E, input, XLEN, sign-extended immediate, instruction PC, PC+4.
REQ-006 SHALL have RdE, input, 5, destination register.
REQ-007 SHALL have RegWriteE, MemWriteE, ALUSrcE, BranchE, input, 1 each, decode control bits.
REQ-008 SHALL have ResultSrcE, input, 1 (0 = ALU, 1 = memory); ALUControlE, input, 3.
REQ-009 SHALL have ForwardAE, ForwardBE, input, 2, forwarding selects from the hazard unit.
REQ-010 SHALL have ResultW, input, XLEN, writeback-stage result.
REQ-011 SHALL have PCSrcE, output, 1, and PCTargetE, output, XLEN, combinational branch-redirect controls.
REQ-012 SHALL have RegWriteM, MemWriteM, ResultSrcM, output, 1 each; RdM, output, 5; ALUResultM, WriteDataM, PCPlus4M, output, XLEN; all registered.

Function
REQ-013 SHALL select SrcAE: ForwardAE 00 -> RD1E, 01 -> ResultW, 10 -> ALUResultM, 11 -> RD1E.
REQ-014 SHALL select the forwarded B operand (WriteDataE) with the same encoding from ForwardBE and RD2E.
REQ-015 SHALL make SrcBE equal to ImmExtE when ALUSrcE = 1, otherwise WriteDataE.
REQ-016 SHALL compute ALUResultE: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 signed slt (result 1 or 0), 110 and 111 -> 0.
REQ-017 SHALL wrap add and sub modulo 2^XLEN; no overflow output.
REQ-018 SHALL assert ZeroE when ALUResultE == 0.
REQ-019 SHALL drive PCTargetE = PCE + ImmExtE modulo 2^XLEN, combinationally.
REQ-020 SHALL drive PCSrcE = ZeroE & BranchE (beq) combinationally, with 0-cycle latency.
REQ-021 SHALL register RegWriteE, MemWriteE, ResultSrcE, RdE, ALUResultE, WriteDataE and PCPlus4E into their M outputs every rising clk edge: 1-cycle latency, no stall or enable.
REQ-022 SHALL feed back the registered ALUResultM (the previous cycle's result) on forward path 10, so back-to-back dependent ALU ops resolve correctly.
REQ-023 SHALL capture WriteDataM after forwarding, so a store reads the forwarded value.

Reset
REQ-024 SHALL, while rst = 0, force all M outputs to 0 asynchronously, independent of clk.
REQ-025 SHALL leave PCSrcE and PCTargetE combinational during reset; they follow their inputs.
REQ-026 SHALL resume capture on the first rising clk edge after rst deasserts, with no bubble cycle.
REQ-027 SHALL clear the pipeline register when reset asserts mid-operation; the in-flight instruction is discarded.

Structure
REQ-028 SHALL place the ALUControl encodings, the Forward encodings (FWD_RF = 00, FWD_WB = 01, FWD_MEM = 10) and XLEN in a shared package.
REQ-029 SHALL instantiate exactly one sub-module, alu (operands, ALUControl, result, zero).
REQ-030 SHALL implement the execute-to-memory pipeline register inline, in one always block.

Verification
REQ-031 Bench SHALL check: RD1E = 5, RD2E = 7, ALUControlE = 000, forwards 00, RdE = 3, RegWriteE = 1 -> next cycle ALUResultM = 12, RdM = 3, RegWriteM = 1.
REQ-032 Bench SHALL check: ALUResultM = 20, ForwardAE = 10, RD1E = 1, RD2E = 2, op add -> ALUResultE = 22; with ForwardBE = 01 and ResultW = 9 instead -> 29.
REQ-033 Bench SHALL check: BranchE = 1, RD1E = RD2E = 4, op sub, PCE = 0x100, ImmExtE = 0xFFFFFFF8 -> PCSrcE = 1, PCTargetE = 0xF8 in the same cycle.
REQ-034 Bench SHALL check: op slt with RD1E = 0xFFFFFFFF, RD2E = 1 -> 1; op add of 0xFFFFFFFF + 1 -> 0, ZeroE = 1.
REQ-035 Bench SHALL check: ALUSrcE = 1, ImmExtE = 16, MemWriteE = 1, ForwardBE = 01, ResultW = 0xAB -> SrcBE = 16, WriteDataM = 0xAB.
REQ-036 Bench SHALL check: rst pulled low between clk edges with M outputs nonzero -> all M outputs 0 immediately; they stay 0 until the first edge after release.
